// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the streaming Sobel engine.
// Width derivation and gradient absolute value live here.
package sobel_pkg;

  localparam logic MODE_MAG = 1'b0;
  localparam logic MODE_THR = 1'b1;

  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

  function automatic int mag_w(input int pix_w);
    return pix_w + 3;
  endfunction

  function automatic logic [31:0] abs_grad(
    input logic signed [31:0] g
  );
    return (g < 0) ? 32'(-g) : 32'(g);
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-port line memory, read-before-write.
// Registered read; nothing changes while en is low.
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel engine: line buffers, window,
// gradient and output stages under one stall enable.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_sof,
  input  logic [PIX_W-1:0]         s_pixel,
  input  logic                     cfg_mode,
  input  logic [mag_w(PIX_W)-1:0]  cfg_thresh,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_sof,
  output logic [PIX_W-1:0]         m_pixel
);

  localparam int GRAD_W = grad_w(PIX_W);
  localparam int MAG_W  = mag_w(PIX_W);
  localparam int CW     = $clog2(IMG_W);
  localparam logic [MAG_W-1:0] PIX_MAX =
    MAG_W'({PIX_W{1'b1}});

  logic en, acc;
  assign en      = !(m_valid && !m_ready);
  assign s_ready = en;
  assign acc     = s_valid && en;

  logic [CW-1:0]    col, col_e, col_n;
  logic [1:0]       row, row_e, row_n;
  logic             sel, sel_e, sel_n, wrap;
  logic             mode_r, mode_e;
  logic [MAG_W-1:0] thr_r, thr_e;

  always_comb begin
    col_e  = s_sof ? '0 : col;
    row_e  = s_sof ? '0 : row;
    sel_e  = s_sof ? 1'b0 : sel;
    wrap   = (col_e == CW'(IMG_W - 1));
    col_n  = wrap ? '0 : col_e + CW'(1);
    row_n  = (wrap && row_e != 2'd2) ? row_e + 2'd1 : row_e;
    sel_n  = sel_e ^ wrap;
    mode_e = s_sof ? cfg_mode : mode_r;
    thr_e  = s_sof ? cfg_thresh : thr_r;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col    <= '0;
      row    <= '0;
      sel    <= 1'b0;
      mode_r <= MODE_MAG;
      thr_r  <= '0;
    end else if (acc) begin
      col <= col_n;
      row <= row_n;
      sel <= sel_n;
      if (s_sof) begin
        mode_r <= cfg_mode;
        thr_r  <= cfg_thresh;
      end
    end
  end

  // The buffer holding the older line is overwritten with the new one;
  // sel flips per line so the two buffers swap roles.
  logic [PIX_W-1:0] a_q, b_q;

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_a (
    .clk   (clk),
    .en    (acc),
    .we    (!sel_e),
    .addr  (col_e),
    .wdata (s_pixel),
    .rdata (a_q)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_b (
    .clk   (clk),
    .en    (acc),
    .we    (sel_e),
    .addr  (col_e),
    .wdata (s_pixel),
    .rdata (b_q)
  );

  logic             v0, v1, v2;
  logic             sof0, sof1, sof2;
  logic             bord0, bord1, bord2;
  logic             mode0, mode1, mode2;
  logic [MAG_W-1:0] thr0, thr1, thr2;
  logic             sel0;
  logic [PIX_W-1:0] pix0;
  logic [PIX_W-1:0] z1, z2, z3, z4, z5, z6, z7, z8, z9;
  logic signed [GRAD_W-1:0] gx, gy;
  logic [GRAD_W-1:0] gx_c, gy_c;
  logic [MAG_W-1:0]  mag;
  logic [PIX_W-1:0]  res;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (en) begin
      v0 <= s_valid;
      v1 <= v0;
      v2 <= v1;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      sof0  <= s_sof;
      bord0 <= (row_e < 2'd2) || (col_e < CW'(2));
      mode0 <= mode_e;
      thr0  <= thr_e;
      sel0  <= sel_e;
      pix0  <= s_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (en && v0) begin
      sof1  <= sof0;
      bord1 <= bord0;
      mode1 <= mode0;
      thr1  <= thr0;
      z1 <= z2;
      z2 <= z3;
      z3 <= sel0 ? b_q : a_q;
      z4 <= z5;
      z5 <= z6;
      z6 <= sel0 ? a_q : b_q;
      z7 <= z8;
      z8 <= z9;
      z9 <= pix0;
    end
  end

  always_comb begin
    gx_c = (GRAD_W'(z3) + (GRAD_W'(z6) << 1) + GRAD_W'(z9))
         - (GRAD_W'(z1) + (GRAD_W'(z4) << 1) + GRAD_W'(z7));
    gy_c = (GRAD_W'(z1) + (GRAD_W'(z2) << 1) + GRAD_W'(z3))
         - (GRAD_W'(z7) + (GRAD_W'(z8) << 1) + GRAD_W'(z9));
  end

  always_ff @(posedge clk) begin
    if (en && v1) begin
      sof2  <= sof1;
      bord2 <= bord1;
      mode2 <= mode1;
      thr2  <= thr1;
      gx    <= $signed(gx_c);
      gy    <= $signed(gy_c);
    end
  end

  always_comb begin
    mag = MAG_W'(abs_grad(32'(gx))) + MAG_W'(abs_grad(32'(gy)));
    res = '0;
    if (!bord2) begin
      if (mode2 == MODE_THR)
        res = (mag >= thr2) ? '1 : '0;
      else if (mag > PIX_MAX)
        res = '1;
      else
        res = mag[PIX_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_sof   <= 1'b0;
      m_pixel <= '0;
    end else if (en) begin
      m_valid <= v2;
      m_sof   <= v2 && sof2;
      if (v2) m_pixel <= res;
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream on an 8x4 frame,
// checked against a direct 2-D Sobel reference.
module tb_sobel_stream;

  localparam int PW = 8;
  localparam int IW = 8;
  localparam int MW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_sof = 1'b0;
  logic [PW-1:0] s_pixel = '0;
  logic          cfg_mode = 1'b0;
  logic [MW-1:0] cfg_thresh = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_sof;
  logic [PW-1:0] m_pixel;

  always #5 clk = ~clk;

  sobel_stream #(.PIX_W(PW), .IMG_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_sof      (s_sof),
    .s_pixel    (s_pixel),
    .cfg_mode   (cfg_mode),
    .cfg_thresh (cfg_thresh),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_sof      (m_sof),
    .m_pixel    (m_pixel)
  );

  int vecs = 0;
  int errs = 0;
  int img [4][8];
  logic          cur_mode = 1'b0;
  logic [MW-1:0] cur_thr = '0;
  logic [8:0] expq [$];
  logic [8:0] gotq [$];
  bit rnd_ready = 1'b0;
  int gap_pct = 0;
  int cyc = 0;
  int first_acc = -1;
  int first_out = -1;
  bit arm = 1'b0;
  bit hold = 1'b0;
  logic [8:0] held;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input int r, input int c);
    int gx, gy, mag;
    if (r < 2 || c < 2) return 8'd0;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c])
       - (img[r][c-2] + 2*img[r][c-1] + img[r][c]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (cur_mode) return (mag >= int'(cur_thr)) ? 8'hff : 8'h00;
    return (mag > 255) ? 8'hff : 8'(mag);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (arm && s_valid && s_ready && first_acc < 0) first_acc = cyc;
    if (hold) check("stall_hold", {23'd0, m_valid, m_sof, m_pixel},
                    {23'd0, 1'b1, held});
    hold = rst_n && m_valid && !m_ready;
    held = {m_sof, m_pixel};
    if (rst_n && m_valid && m_ready) gotq.push_back({m_sof, m_pixel});
  end

  always @(negedge clk)
    if (arm && m_valid && first_out < 0) first_out = cyc;

  initial forever begin
    @(negedge clk);
    m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send_pix(input int r, input int c, input bit sof);
    int n = 0;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_sof = sof;
    s_pixel = 8'(img[r][c]);
    cfg_mode = cur_mode;
    cfg_thresh = cur_thr;
    do begin
      @(posedge clk);
      n++;
    end while (!s_ready && n < 1000);
    if (n >= 1000) check("accept_timeout", {31'd0, s_ready}, 32'd1);
    expq.push_back({sof, model(r, c)});
    @(negedge clk);
    s_valid = 1'b0;
    s_sof = 1'b0;
  endtask

  task automatic send_frame(input int n);
    for (int k = 0; k < n; k++) send_pix(k / IW, k % IW, k == 0);
  endtask

  task automatic drain_check(input string tag);
    int t = 0;
    logic [8:0] g;
    while (gotq.size() < expq.size() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    check({tag, "_count"}, gotq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      g = (i < gotq.size()) ? gotq[i] : 9'bx;
      check($sformatf("%s_beat%0d", tag, i), {23'd0, g},
            {23'd0, expq[i]});
    end
  endtask

  task automatic clear_q();
    expq.delete();
    gotq.delete();
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < IW; c++)
        case (kind)
          0: img[r][c] = 100;
          1: img[r][c] = (c < 4) ? 0 : 255;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_sof", {31'd0, m_sof}, 32'd0);
    check("rst_m_pixel", {24'd0, m_pixel}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);

    fill(0);
    cur_mode = 1'b0;
    arm = 1'b1;
    send_frame(32);
    drain_check("const");
    arm = 1'b0;
    check("latency", 32'(first_out - first_acc), 32'd3);
    check("const_sof_first", {31'd0, gotq[0][8]}, 32'd1);
    clear_q();

    fill(1);
    send_frame(32);
    drain_check("step_mag");
    check("step_c4", {23'd0, gotq[20]}, 32'h0ff);
    check("step_c5", {23'd0, gotq[29]}, 32'h0ff);
    check("step_c3", {23'd0, gotq[19]}, 32'h000);
    check("step_c6", {23'd0, gotq[22]}, 32'h000);
    check("step_row1", {23'd0, gotq[12]}, 32'h000);
    clear_q();

    cur_mode = 1'b1;
    cur_thr = 11'd1020;
    send_frame(32);
    drain_check("step_thr1020");
    check("thr1020_c4", {23'd0, gotq[28]}, 32'h0ff);
    clear_q();
    cur_thr = 11'd1021;
    send_frame(32);
    drain_check("step_thr1021");
    check("thr1021_c4", {23'd0, gotq[28]}, 32'h000);
    clear_q();

    rnd_ready = 1'b1;
    gap_pct = 30;
    fill(2);
    cur_mode = 1'b0;
    send_frame(32);
    fill(2);
    cur_mode = 1'b1;
    cur_thr = 11'd300;
    send_frame(32);
    fill(2);
    cur_mode = 1'b0;
    send_frame(32);
    drain_check("random");
    clear_q();
    rnd_ready = 1'b0;
    gap_pct = 0;
    repeat (3) @(negedge clk);

    fill(2);
    send_frame(13);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    clear_q();
    fill(2);
    send_frame(32);
    drain_check("after_rst");
    clear_q();

    fill(2);
    send_frame(21);
    fill(2);
    send_frame(32);
    drain_check("sof_restart");
    check("restart_sof", {31'd0, gotq[21][8]}, 32'd1);
    check("restart_border", {23'd0, gotq[21+9]}, 32'h000);
    clear_q();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/sobel_stream.md
# sobel_stream

Streaming, parametrised Sobel edge engine and the successor to the team's combinational Sobel core. It accepts one raster-order pixel per valid/ready beat and builds the 3x3 window internally from two line buffers. It computes Gx/Gy in a registered pipeline and emits either a clamped |Gx|+|Gy| magnitude or a binary edge map. It sits between the frame source and the output writer, and the output stream supports backpressure.

## Interface
Parameters:
- PIX_W, 8, pixel bit width.
- IMG_W, 640, pixels per line (≥4).
- Derived (not overridable): GRAD_W = PIX_W+3 (signed gradient width); MAG_W = PIX_W+3 (unsigned |Gx|+|Gy| width).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when s_valid && s_ready.
- s_sof  in  1  qualifies the accepted beat as the first pixel of a frame.
- s_pixel  in  PIX_W  input pixel, unsigned.
- cfg_mode  in  1  0 = magnitude, 1 = binary threshold; sampled on each accepted s_sof beat.
- cfg_thresh  in  MAG_W  threshold; sampled with cfg_mode.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream ready.
- m_sof  out  1  marks the output beat produced from the s_sof beat.
- m_pixel  out  PIX_W  edge result.

## Operation
- Pipeline enable: en = !(m_valid && !m_ready). s_ready = en. No combinational path from s_valid to s_ready.
- Counters: col 0..IMG_W-1 wraps to 0 and increments row. row saturates at 2. An accepted s_sof beat forces col=0, row=0 for that pixel, so the frame restarts mid-frame with no error.
- Line buffers: two IMG_W-deep buffers, read-before-write at address col. Line1 holds the previous line and line0 holds the line before it. The column of 3 pixels {line0, line1, s_pixel} shifts into a 3x3 window register (Z1..Z9, row-major, Z9 newest).
- Window centre is (row-1, col-1) of the accepted beat. The window is tagged border when row<2 or col<2 at acceptance.
- Stage G: gx = (Z3+2Z6+Z9) − (Z1+2Z4+Z7); gy = (Z1+2Z2+Z3) − (Z7+2Z8+Z9). Both are signed GRAD_W with no overflow (|g| ≤ 4·(2^PIX_W−1)).
- Stage O: mag = |gx|+|gy| in MAG_W.
  - Magnitude mode: m_pixel = min(mag, 2^PIX_W−1).
  - Threshold mode: m_pixel = all-ones if mag ≥ cfg_thresh, else 0.
  - Border-tagged results: m_pixel = 0 in both modes.
- One output beat per accepted input beat. Output is ordered and never dropped or duplicated. m_sof travels with its beat.
- Reset values:
  - s_ready=1 (after reset deasserts), m_valid=0, m_sof=0, m_pixel=0.
  - col=0, row=0, all pipeline valid bits 0, mode=0, thresh=0.
  - Line-buffer contents are don't-care, because border tagging masks them.
- Reset mid-frame drops all in-flight beats. The next frame must start with s_sof.

## Timing
- Latency: a beat accepted at edge N is presented on m_* after edge N+3, with 3 register stages (window, gradient, output). Latency is fixed when m_ready stays high.
- Throughput is 1 pixel/cycle when m_ready=1.
- When en=0, every stage, both counters and the line buffers hold their values. m_valid/m_pixel/m_sof are stable until taken.
- Bubbles (s_valid=0 with en=1) advance the pipeline with invalid entries. Counters and buffers do not change on bubbles.
- A config sample on an s_sof beat applies from that beat's own output onward. In-flight beats keep the previous mode.

## Structure
- sobel_pkg: the mode constants MODE_MAG and MODE_THR, plus functions for GRAD_W/MAG_W derivation and for abs of a signed GRAD_W value.
- Sub-module sobel_line_buffer (parameters DEPTH, WIDTH): single-port read-before-write memory with a registered read and enable. Instantiate it twice.
- Top level contains the counters, window register, two arithmetic stages and the valid/ready control. Target 200–300 lines.

## Test plan
- IMG_W=8, 8x4 frame of constant 100, magnitude mode → 32 outputs, all 0, m_sof on first only, first output 3 cycles after first accept.
- Vertical step (cols 0–3 = 0, cols 4–7 = 255), magnitude mode:
  - rows ≥2, centre cols 3,4 → 255 (mag 1020 clamped).
  - other interior positions → 0.
  - border positions → 0.
- Same step image, threshold mode with cfg_thresh=1020 → centre cols 3,4 = 255. Repeat with cfg_thresh=1021 → all 0.
- Random m_ready (50%) and random s_valid gaps over 3 frames → output sequence matches a reference model with no loss or duplication, and m_* stays stable while stalled.
- rst_n low for 1 cycle mid-frame, then a new s_sof frame → no stale outputs, and the new frame output matches the model.
- s_sof asserted at col 5 of row 2 → counters restart, and the following 2 lines plus 2 columns of outputs are 0 (border).
